// File: rtl/contador_ms_objetivo.sv
// Millisecond counter with a loadable target: counts whole milliseconds
// from a prescaled clock, pauses/resumes without losing sub-ms progress.
module contador_ms_objetivo #(
  parameter int DIV_MS = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] objetivo,
  input  logic        carga,
  input  logic        inicio,
  input  logic        detener,
  output logic [15:0] cuenta,
  output logic        tick_ms,
  output logic        fin,
  output logic        ocupado,
  output logic [1:0]  estado
);

  localparam int PW = (DIV_MS > 2) ? $clog2(DIV_MS) : 1;
  // The tick is launched one cycle before presc shows DIV_MS-1, so the
  // registered tick_ms lines up with the last prescaler count of each ms.
  localparam logic [PW-1:0] PRESC_TICK = PW'(DIV_MS - 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_MS - 1);

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSA    = 2'b10,
    FIN      = 2'b11
  } estado_t;

  estado_t        r_estado;
  logic [15:0]    r_objetivo;
  logic [15:0]    r_cuenta;
  logic [PW-1:0]  r_presc;
  logic           r_tick;
  logic           r_fin;
  logic           r_ocupado;

  logic           w_tick_gen;
  logic           w_terminal;
  logic [PW-1:0]  w_presc_next;
  logic [15:0]    w_cuenta_inc;

  assign w_tick_gen   = (r_presc == PRESC_TICK);
  assign w_presc_next = (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
  assign w_cuenta_inc = r_cuenta + 16'd1;
  assign w_terminal   = (w_cuenta_inc == r_objetivo);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= REPOSO;
      r_objetivo <= '0;
      r_cuenta   <= '0;
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_fin      <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_fin  <= 1'b0;
      case (r_estado)
        REPOSO, FIN: begin
          // carga outranks inicio; detener has no meaning while idle
          if (carga) begin
            r_objetivo <= objetivo;
            r_cuenta   <= '0;
            r_presc    <= '0;
            r_estado   <= REPOSO;
            r_ocupado  <= 1'b0;
          end else if (inicio) begin
            r_cuenta <= '0;
            r_presc  <= '0;
            if (r_objetivo != 16'd0) begin
              r_estado  <= CONTANDO;
              r_ocupado <= 1'b1;
            end else begin
              r_estado  <= FIN;
              r_fin     <= 1'b1;
              r_ocupado <= 1'b0;
            end
          end
        end

        CONTANDO: begin
          // The detener cycle still counts, so a tick launched in it lands.
          r_presc <= w_presc_next;
          if (w_tick_gen) begin
            r_tick   <= 1'b1;
            r_cuenta <= w_cuenta_inc;
            if (w_terminal) begin
              r_estado  <= FIN;
              r_fin     <= 1'b1;
              r_ocupado <= 1'b0;
            end else if (detener) begin
              r_estado <= PAUSA;
            end
          end else if (detener) begin
            r_estado <= PAUSA;
          end
        end

        PAUSA: begin
          if (inicio && !detener) begin
            r_estado <= CONTANDO;
          end
        end

        default: begin
          r_estado  <= REPOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign cuenta  = r_cuenta;
  assign tick_ms = r_tick;
  assign fin     = r_fin;
  assign ocupado = r_ocupado;
  assign estado  = r_estado;

endmodule

// File: tb/tb_contador_ms_objetivo.sv
// Bench for contador_ms_objetivo at DIV_MS=4: directed scenarios push the
// expected tick/fin events to a queue; a negedge monitor pops and compares.
module tb_contador_ms_objetivo;

  localparam int D = 4;
  localparam logic [1:0] S_REPOSO = 2'b00;
  localparam logic [1:0] S_CONT   = 2'b01;
  localparam logic [1:0] S_PAUSA  = 2'b10;
  localparam logic [1:0] S_FIN    = 2'b11;

  logic        clk;
  logic        rst;
  logic [15:0] objetivo;
  logic        carga;
  logic        inicio;
  logic        detener;
  logic [15:0] cuenta;
  logic        tick_ms;
  logic        fin;
  logic        ocupado;
  logic [1:0]  estado;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // event word: {cycle[31:0], cuenta[15:0], tick_ms, fin, estado[1:0]}
  logic [51:0] exp_q[$];

  contador_ms_objetivo #(.DIV_MS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .objetivo (objetivo),
    .carga    (carga),
    .inicio   (inicio),
    .detener  (detener),
    .cuenta   (cuenta),
    .tick_ms  (tick_ms),
    .fin      (fin),
    .ocupado  (ocupado),
    .estado   (estado)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] c, input logic tk,
                          input logic f, input logic oc, input logic [1:0] st);
    chk(tag, 64'({cuenta, tick_ms, fin, ocupado, estado}), 64'({c, tk, f, oc, st}));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [51:0] got;
    logic [51:0] e;
    if (tick_ms === 1'b1 || fin === 1'b1) begin
      got = {cyc[31:0], cuenta, tick_ms, fin, estado};
      if (exp_q.size() == 0) begin
        chk("spurious_event", 64'(got), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event", 64'(got), 64'(e));
      end
    end
  end

  // driver tasks
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick_n(1);
  endtask

  task automatic pulse(input logic c, input logic i, input logic d,
                       input logic [15:0] obj, output int t);
    carga = c; inicio = i; detener = d; objetivo = obj;
    t = cyc;
    tick_n(1);
    carga = 1'b0; inicio = 1'b0; detener = 1'b0;
  endtask

  task automatic push_ev(input int at, input logic [15:0] c, input logic tk,
                         input logic f, input logic [1:0] st);
    exp_q.push_back({at[31:0], c, tk, f, st});
  endtask

  // full uninterrupted count of n ms starting from an inicio at cycle t
  task automatic push_count(input int t, input int n);
    for (int k = 1; k <= n; k++) begin
      if (k == n) push_ev(t + k * D, 16'(k), 1'b1, 1'b1, S_FIN);
      else        push_ev(t + k * D, 16'(k), 1'b1, 1'b0, S_CONT);
    end
  endtask

  task automatic chk_pending(input string tag);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t, p, x;
    rst = 1'b1; carga = 1'b0; inicio = 1'b0; detener = 1'b0; objetivo = '0;
    tick_n(3);
    chk_outs("reset_state", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    rst = 1'b0;
    tick_n(1);

    // inicio with no prior carga: target 0 -> immediate FIN
    push_ev(cyc + 1, 16'd0, 1'b0, 1'b1, S_FIN);
    pulse(0, 1, 0, 16'd0, t);
    tick_n(1);
    chk_outs("after_reset_fin", 16'd0, 1'b0, 1'b0, 1'b0, S_FIN);

    // basic count, target 3
    pulse(1, 0, 0, 16'd3, t);
    chk_outs("carga_from_fin", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    pulse(0, 1, 0, 16'd0, t);
    push_count(t, 3);
    chk_outs("basic_start", 16'd0, 1'b0, 1'b0, 1'b1, S_CONT);
    wait_until(t + 13);
    chk_outs("basic_end", 16'd3, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("basic_pending");

    // restart from FIN repeats the same timing
    pulse(0, 1, 0, 16'd0, t);
    push_count(t, 3);
    chk_outs("restart_start", 16'd0, 1'b0, 1'b0, 1'b1, S_CONT);
    wait_until(t + 13);
    chk_outs("restart_end", 16'd3, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("restart_pending");

    // pause two cycles after the first tick, hold 10 cycles, resume
    pulse(1, 0, 0, 16'd5, t);
    pulse(0, 1, 0, 16'd0, t);
    push_ev(t + 4, 16'd1, 1'b1, 1'b0, S_CONT);
    wait_until(t + 6);
    pulse(0, 0, 1, 16'd0, x);
    chk_outs("paused", 16'd1, 1'b0, 1'b0, 1'b1, S_PAUSA);
    for (int k = 0; k < 10; k++) begin
      tick_n(1);
      chk("pause_hold", 64'({cuenta, estado}), 64'({16'd1, S_PAUSA}));
    end
    pulse(0, 1, 0, 16'd0, p);
    push_ev(p + 2,  16'd2, 1'b1, 1'b0, S_CONT);
    push_ev(p + 6,  16'd3, 1'b1, 1'b0, S_CONT);
    push_ev(p + 10, 16'd4, 1'b1, 1'b0, S_CONT);
    push_ev(p + 14, 16'd5, 1'b1, 1'b1, S_FIN);
    wait_until(p + 15);
    chk_outs("pause_end", 16'd5, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("pause_pending");

    // detener in the cycle that launches a tick
    pulse(1, 0, 0, 16'd2, t);
    pulse(0, 1, 0, 16'd0, t);
    wait_until(t + 3);
    push_ev(t + 4, 16'd1, 1'b1, 1'b0, S_PAUSA);
    pulse(0, 0, 1, 16'd0, x);
    chk_outs("wrap_pause", 16'd1, 1'b1, 1'b0, 1'b1, S_PAUSA);
    tick_n($urandom_range(2, 6));
    pulse(0, 1, 1, 16'd0, x);
    chk_outs("both_in_pausa", 16'd1, 1'b0, 1'b0, 1'b1, S_PAUSA);
    tick_n($urandom_range(1, 4));
    pulse(0, 1, 0, 16'd0, p);
    push_ev(p + 5, 16'd2, 1'b1, 1'b1, S_FIN);
    wait_until(p + 6);
    chk_outs("wrap_end", 16'd2, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("wrap_pending");

    // inicio+detener in CONTANDO, carga ignored in PAUSA and CONTANDO
    pulse(1, 0, 0, 16'd3, t);
    pulse(0, 1, 0, 16'd0, t);
    pulse(0, 1, 1, 16'd0, x);
    chk_outs("both_in_cont", 16'd0, 1'b0, 1'b0, 1'b1, S_PAUSA);
    pulse(1, 0, 0, 16'd1, x);
    chk_outs("carga_in_pausa", 16'd0, 1'b0, 1'b0, 1'b1, S_PAUSA);
    pulse(0, 1, 0, 16'd0, p);
    push_ev(p + 3,  16'd1, 1'b1, 1'b0, S_CONT);
    push_ev(p + 7,  16'd2, 1'b1, 1'b0, S_CONT);
    push_ev(p + 11, 16'd3, 1'b1, 1'b1, S_FIN);
    pulse(1, 0, 0, 16'd1, x);
    chk_outs("carga_in_cont", 16'd0, 1'b0, 1'b0, 1'b1, S_CONT);
    wait_until(p + 12);
    chk_outs("ignored_end", 16'd3, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("ignored_pending");

    // carga+inicio in FIN: reload only, no count
    pulse(1, 1, 0, 16'd2, t);
    chk_outs("carga_inicio_fin", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    tick_n(5);
    chk_outs("still_reposo", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    pulse(0, 1, 0, 16'd0, t);
    push_count(t, 2);
    wait_until(t + 9);
    chk_outs("new_target_end", 16'd2, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("new_target_pending");

    // boundary targets 0 and 1
    pulse(1, 0, 0, 16'd0, t);
    push_ev(cyc + 1, 16'd0, 1'b0, 1'b1, S_FIN);
    pulse(0, 1, 0, 16'd0, t);
    tick_n(1);
    chk_outs("zero_target", 16'd0, 1'b0, 1'b0, 1'b0, S_FIN);
    pulse(1, 0, 0, 16'd1, t);
    pulse(0, 1, 0, 16'd0, t);
    push_ev(t + D, 16'd1, 1'b1, 1'b1, S_FIN);
    wait_until(t + D + 1);
    chk_outs("one_target", 16'd1, 1'b0, 1'b0, 1'b0, S_FIN);
    chk_pending("bound_pending");

    // reset mid-count at cuenta=2 of 3
    pulse(1, 0, 0, 16'd3, t);
    pulse(0, 1, 0, 16'd0, t);
    push_ev(t + 4, 16'd1, 1'b1, 1'b0, S_CONT);
    push_ev(t + 8, 16'd2, 1'b1, 1'b0, S_CONT);
    wait_until(t + 9);
    chk("cuenta_before_rst", 64'(cuenta), 64'd2);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    chk_outs("rst_mid", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    wait_until(t + 16);
    chk_outs("rst_idle", 16'd0, 1'b0, 1'b0, 1'b0, S_REPOSO);
    chk_pending("rst_pending");
    push_ev(cyc + 1, 16'd0, 1'b0, 1'b1, S_FIN);
    pulse(0, 1, 0, 16'd0, t);
    tick_n(2);
    chk_outs("rst_then_inicio", 16'd0, 1'b0, 1'b0, 1'b0, S_FIN);

    tick_n(4);
    chk_pending("drain");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
